// File: rtl/sd_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sd_cmd_pkg
// Shared definitions for the SD command-line blocks (transmitter and response
// receiver): frame geometry, CRC7 polynomial, fixed frame bits, FSM state
// enums and a single-step CRC7 helper.
// No ports (package).
// -----------------------------------------------------------------------------
package sd_cmd_pkg;

    localparam int FRAME_W   = 48;  // start + tx + index + argument + crc + end
    localparam int PAYLOAD_W = 40;  // start + tx + index + argument
    localparam int CRC_W     = 7;

    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

    localparam logic START_BIT   = 1'b0;
    localparam logic TX_BIT_HOST = 1'b1;  // transmission bit: host -> card
    localparam logic END_BIT     = 1'b1;

    // Bit-counter values marking the last payload bit and the CRC window.
    localparam logic [5:0] LAST_PAYLOAD_BIT = 6'd39;
    localparam logic [5:0] FIRST_CRC_BIT    = 6'd40;
    localparam logic [5:0] LAST_CRC_BIT     = 6'd46;

    // Transmitter FSM.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_FRAME,
        S_SEND_CRC,
        S_SEND_END,
        S_GAP,
        S_COMPLITE
    } cmd_send_state_t;

    // Response receiver FSM (lives here so both blocks share one package).
    typedef enum logic [2:0] {
        R_IDLE,
        R_WAIT_START,
        R_RECV,
        R_CHECK,
        R_COMPLITE
    } cmd_recv_state_t;

    // One serial CRC7 step: MSB-first, feedback = crc[6] ^ incoming bit.
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                   input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// -----------------------------------------------------------------------------
// sd_crc7_serial
// Bit-serial CRC7 accumulator (x^7 + x^3 + 1, init 0), shared by the command
// transmitter and the response receiver.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset (clears crc)
//   clr     synchronous clear to 0 (has priority over en)
//   en      fold bit_in into the CRC this cycle
//   bit_in  serial data bit, MSB first
//   crc     current CRC7 value
// -----------------------------------------------------------------------------
module sd_crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_cmd_send.sv
// -----------------------------------------------------------------------------
// sd_cmd_send
// SD CMD-line transmitter. Builds the 48-bit command frame (start, transmission
// bit, 6-bit index, 32-bit argument, CRC7, end), shifts it out one bit per
// clock, holds the line high for NCC_CYCLES, then releases the line so the
// response receiver can sample the card.
//
// Handshake (Enable/Complite, level-held, same as the receiver):
//   - Enable is sampled only in S_IDLE; the cycle it is seen high the index and
//     argument are captured and the start bit goes out on the next cycle.
//   - From acceptance until S_COMPLITE, Enable and Command/Argument are ignored.
//   - In S_COMPLITE, Complite is high for as long as Enable stays high; once the
//     host drops Enable, Complite falls on the following cycle and the block
//     returns to S_IDLE. A new frame therefore needs Enable low for at least one
//     sampled cycle.
//
// Ports:
//   clk       system clock, one cmd bit per cycle
//   rst       asynchronous active-high reset; aborts any frame, releases cmd
//   Enable    send request (level)
//   Command   6-bit command index, captured at acceptance
//   Argument  32-bit argument, captured at acceptance
//   cmd       SD CMD line; driven during frame and gap, otherwise 1'bz
//   Busy      high from the cycle after acceptance until the line is released
//   Complite  frame sent and line released; held while Enable stays high
//   Crc_Out   CRC7 of the last transmitted frame
// -----------------------------------------------------------------------------
module sd_cmd_send
    import sd_cmd_pkg::*;
#(
    parameter int NCC_CYCLES = 8  // 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Enable,
    input  logic [5:0]  Command,
    input  logic [31:0] Argument,
    inout  wire         cmd,
    output logic        Busy,
    output logic        Complite,
    output logic [6:0]  Crc_Out
);

    localparam logic [7:0] GAP_LAST = 8'(NCC_CYCLES - 1);

    cmd_send_state_t state, state_next;

    logic [PAYLOAD_W-1:0] shreg;
    logic [5:0]           bit_cnt;
    logic [7:0]           gap_cnt;

    logic       cmd_oe;
    logic       cmd_bit;
    logic       crc_clr;
    logic       crc_en;
    logic [6:0] crc_val;
    logic [6:0] crc_shifted;

    // ---------------------------------------------------------------- CRC7
    // Only payload bits feed the CRC; the CRC bits themselves are sent from
    // the held value so the register stays valid for Crc_Out.
    sd_crc7_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (shreg[PAYLOAD_W-1]),
        .crc    (crc_val)
    );

    // During S_SEND_CRC bit_cnt runs 40..46 (6'b101_000..6'b101_110), so its
    // low three bits are exactly how far the CRC has been shifted left.
    assign crc_shifted = crc_val << bit_cnt[2:0];

    // ---------------------------------------------------------------- FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------- FSM comb
    always_comb begin
        state_next = state;
        cmd_oe     = 1'b0;
        cmd_bit    = 1'b1;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        Busy       = 1'b0;

        case (state)
            S_IDLE: begin
                if (Enable) begin
                    crc_clr    = 1'b1;
                    state_next = S_SEND_FRAME;
                end
            end

            S_SEND_FRAME: begin
                cmd_oe  = 1'b1;
                cmd_bit = shreg[PAYLOAD_W-1];
                crc_en  = 1'b1;
                Busy    = 1'b1;
                if (bit_cnt == LAST_PAYLOAD_BIT) begin
                    state_next = S_SEND_CRC;
                end
            end

            S_SEND_CRC: begin
                cmd_oe  = 1'b1;
                cmd_bit = crc_shifted[6];
                Busy    = 1'b1;
                if (bit_cnt == LAST_CRC_BIT) begin
                    state_next = S_SEND_END;
                end
            end

            S_SEND_END: begin
                cmd_oe     = 1'b1;
                cmd_bit    = END_BIT;
                Busy       = 1'b1;
                state_next = S_GAP;
            end

            S_GAP: begin
                cmd_oe  = 1'b1;
                cmd_bit = 1'b1;
                Busy    = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    state_next = S_COMPLITE;
                end
            end

            S_COMPLITE: begin
                if (!Enable) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            Crc_Out  <= '0;
            Complite <= 1'b0;
        end else begin
            // Registered so that Complite only rises if Enable is still high
            // when S_COMPLITE is (re)entered, and falls the cycle after the
            // host drops Enable.
            Complite <= (state_next == S_COMPLITE) && Enable;

            case (state)
                S_IDLE: begin
                    if (Enable) begin
                        shreg   <= {START_BIT, TX_BIT_HOST, Command, Argument};
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end
                end

                S_SEND_FRAME: begin
                    shreg   <= {shreg[PAYLOAD_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 6'd1;
                end

                S_SEND_CRC: begin
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == FIRST_CRC_BIT) begin
                        Crc_Out <= crc_val;
                    end
                end

                S_GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end

                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- CMD pin
    assign cmd = cmd_oe ? cmd_bit : 1'bz;

endmodule

// File: tb/tb_sd_cmd_send.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_send
// Self-checking bench for sd_cmd_send. Two instances: dut0 (NCC_CYCLES=8) and
// dut1 (NCC_CYCLES=1). The cmd lines carry weak pull-downs, so a released line
// reads 0 and the high gap is distinguishable from release.
// -----------------------------------------------------------------------------
module tb_sd_cmd_send;

    // ---------------------------------------------------------- clock / reset
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------- DUT signals
    logic        en0, en1;
    logic [5:0]  Command;
    logic [31:0] Argument;
    wire         cmd0, cmd1;
    logic        busy0, busy1;
    logic        cpl0, cpl1;
    logic [6:0]  crc0, crc1;

    pulldown (cmd0);
    pulldown (cmd1);

    sd_cmd_send #(.NCC_CYCLES(8)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .Enable   (en0),
        .Command  (Command),
        .Argument (Argument),
        .cmd      (cmd0),
        .Busy     (busy0),
        .Complite (cpl0),
        .Crc_Out  (crc0)
    );

    sd_cmd_send #(.NCC_CYCLES(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .Enable   (en1),
        .Command  (Command),
        .Argument (Argument),
        .cmd      (cmd1),
        .Busy     (busy1),
        .Complite (cpl1),
        .Crc_Out  (crc1)
    );

    // ---------------------------------------------------------- scoreboard
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rd_cmd(input bit s);
        return s ? cmd1 : cmd0;
    endfunction

    function automatic logic rd_busy(input bit s);
        return s ? busy1 : busy0;
    endfunction

    function automatic logic rd_cpl(input bit s);
        return s ? cpl1 : cpl0;
    endfunction

    function automatic logic [6:0] rd_crc(input bit s);
        return s ? crc1 : crc0;
    endfunction

    task automatic set_en(input bit s, input logic v);
        if (s) en1 = v;
        else   en0 = v;
    endtask

    // ---------------------------------------------------------- driver
    // Sends one frame and checks it bit by bit. With 'abuse' set, Command is
    // changed at frame bit 10 and Enable dropped at frame bit 20.
    task automatic send_check(input bit s, input logic [5:0] c, input logic [31:0] a,
                              input logic [47:0] ef, input logic [6:0] ec,
                              input bit abuse, input string tag);
        logic [47:0] got;
        int          hi;
        int          ncc;
        ncc = s ? 1 : 8;
        got = '0;

        @(negedge clk);
        Command  = c;
        Argument = a;
        set_en(s, 1'b1);
        @(posedge clk);  // acceptance edge

        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            got = {got[46:0], rd_cmd(s)};
            if (k == 0) chk($sformatf("%s_busy_start", tag), 64'(rd_busy(s)), 64'd1);
            if (abuse && k == 10) Command = ~c;
            if (abuse && k == 20) set_en(s, 1'b0);
        end
        chk($sformatf("%s_frame", tag), 64'(got), 64'(ef));

        hi = 0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (rd_cmd(s) === 1'b1) hi++;
            else break;
        end
        chk($sformatf("%s_gap_len", tag), 64'(hi), 64'(ncc));
        chk($sformatf("%s_crc_out", tag), 64'(rd_crc(s)), 64'(ec));
        chk($sformatf("%s_busy_done", tag), 64'(rd_busy(s)), 64'd0);

        if (!abuse) begin
            chk($sformatf("%s_cpl_entry", tag), 64'(rd_cpl(s)), 64'd1);
            repeat (2) @(negedge clk);
            chk($sformatf("%s_cpl_held", tag), 64'(rd_cpl(s)), 64'd1);
            chk($sformatf("%s_cmd_released", tag), 64'(rd_cmd(s)), 64'd0);
            set_en(s, 1'b0);
            chk($sformatf("%s_cpl_before_fall", tag), 64'(rd_cpl(s)), 64'd1);
            @(negedge clk);
            chk($sformatf("%s_cpl_fall", tag), 64'(rd_cpl(s)), 64'd0);
        end else begin
            chk($sformatf("%s_cpl_never", tag), 64'(rd_cpl(s)), 64'd0);
            @(negedge clk);
            chk($sformatf("%s_cpl_never2", tag), 64'(rd_cpl(s)), 64'd0);
        end
        chk($sformatf("%s_idle_busy", tag), 64'(rd_busy(s)), 64'd0);
        chk($sformatf("%s_idle_cmd", tag), 64'(rd_cmd(s)), 64'd0);
    endtask

    // ---------------------------------------------------------- vectors
    typedef struct {
        bit          sel;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] frame;
        logic [6:0]  crc;
        string       name;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b0, 6'd0,  32'h0000_0000, 48'h40_00_00_00_00_95, 7'h4A, "cmd0"};
        vecs[1] = '{1'b0, 6'd8,  32'h0000_01AA, 48'h48_00_00_01_AA_87, 7'h43, "cmd8"};
        vecs[2] = '{1'b0, 6'd17, 32'h0000_0000, 48'h51_00_00_00_00_55, 7'h2A, "cmd17"};
        vecs[3] = '{1'b0, 6'd55, 32'h0000_0000, 48'h77_00_00_00_00_65, 7'h32, "cmd55"};
        vecs[4] = '{1'b1, 6'd0,  32'h0000_0000, 48'h40_00_00_00_00_95, 7'h4A, "ncc1_cmd0"};

        rst      = 1'b1;
        en0      = 1'b0;
        en1      = 1'b0;
        Command  = '0;
        Argument = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_cmd0",  64'(cmd0),  64'd0);
        chk("rst_cmd1",  64'(cmd1),  64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_cpl0",  64'(cpl0),  64'd0);
        chk("rst_crc0",  64'(crc0),  64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven frames (cmd17 -> cmd55 run back to back with the
        // minimum one-cycle Enable-low gap).
        for (int i = 0; i < 5; i++) begin
            send_check(vecs[i].sel, vecs[i].idx, vecs[i].arg, vecs[i].frame,
                       vecs[i].crc, 1'b0, vecs[i].name);
        end

        // Enable dropped at bit 20, Command changed at bit 10.
        send_check(1'b0, 6'd8, 32'h0000_01AA, 48'h48_00_00_01_AA_87, 7'h43, 1'b1, "abuse");

        // Asynchronous reset mid-frame at bit 30 (argument all ones -> bit is 1).
        @(negedge clk);
        Command  = 6'd3;
        Argument = 32'hFFFF_FFFF;
        en0      = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 30; k++) @(negedge clk);
        chk("pre_rst_bit30", 64'(cmd0), 64'd1);
        chk("pre_rst_busy", 64'(busy0), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_cmd",  64'(cmd0),  64'd0);
        chk("async_rst_busy", 64'(busy0), 64'd0);
        chk("async_rst_crc",  64'(crc0),  64'd0);
        en0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cpl", 64'(cpl0), 64'd0);
        chk("post_rst_cmd", 64'(cmd0), 64'd0);
        send_check(1'b0, 6'd0, 32'h0, 48'h40_00_00_00_00_95, 7'h4A, 1'b0, "after_rst_cmd0");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
